// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 UART receiver that packs eight consecutive bytes into a
// 64-bit word, first byte in [63:56]. Partial words are dropped on a framing
// error, an inter-byte timeout, or an explicit rx_clr flush.
module uart_rx_word #(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 1740
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rx_clr,
  output logic [63:0] rx_reg,
  output logic        rx_valid,
  output logic [3:0]  rx_count,
  output logic        rx_busy,
  output logic        frame_err,
  output logic        rx_timeout
);

  localparam int H      = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDLE_W = $clog2(TIMEOUT_CLKS);

  localparam logic [CNT_W-1:0]  HALF_C = CNT_W'(H);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDLE_W-1:0] TO_C   = IDLE_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         data_byte;
  logic [55:0]        word;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               rx_meta;
  logic               rx_s;
  logic               stop_evt;
  logic               accept;
  logic               bad_stop;

  // Two-flop synchronizer for the asynchronous pin; idles high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign stop_evt = (state == STOP) && (cnt == LAST_C);
  assign accept   = stop_evt && rx_s;
  assign bad_stop = stop_evt && !rx_s;
  assign rx_busy  = (state != IDLE) || (rx_count != 4'd0);

  // Bit FSM plus word assembly, flush, framing-error and timeout handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      word       <= '0;
      rx_reg     <= '0;
      rx_valid   <= 1'b0;
      rx_count   <= '0;
      frame_err  <= 1'b0;
      rx_timeout <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rx_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // Mid-bit recheck; a high line here means the low was a glitch.
          if (cnt == HALF_C) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST_C) begin
            data_byte[bit_idx] <= rx_s;
            cnt                <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // No cleanup state: back in IDLE right after the stop sample.
          if (cnt == LAST_C) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (rx_clr) begin
        rx_count <= '0;
        word     <= '0;
        idle_cnt <= '0;
      end else if (accept) begin
        idle_cnt <= '0;
        if (rx_count == 4'd7) begin
          rx_reg   <= {word, data_byte};
          rx_valid <= 1'b1;
          rx_count <= '0;
          word     <= '0;
        end else begin
          word     <= {word[47:0], data_byte};
          rx_count <= rx_count + 4'd1;
        end
      end else if (bad_stop) begin
        frame_err <= 1'b1;
        rx_count  <= '0;
        word      <= '0;
        idle_cnt  <= '0;
      end else if ((state == IDLE) && (rx_count != 4'd0)) begin
        if (idle_cnt == TO_C) begin
          rx_timeout <= 1'b1;
          rx_count   <= '0;
          word       <= '0;
          idle_cnt   <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed UART frames with a word scoreboard; a monitor
// pops expected words whenever rx_valid strobes and tallies error pulses.
module tb_uart_rx_word;

  localparam int N = 87;
  localparam int H = 43;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        rx_clr;
  logic [63:0] rx_reg;
  logic        rx_valid;
  logic [3:0]  rx_count;
  logic        rx_busy;
  logic        frame_err;
  logic        rx_timeout;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int start_cyc  = 0;
  int valid_cyc  = -1;
  int ferr_seen  = 0;
  int to_seen    = 0;
  int words_seen = 0;
  logic [63:0] exp_q[$];

  uart_rx_word #(.CLKS_PER_BIT(N), .TIMEOUT_CLKS(1740)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_clr     (rx_clr),
    .rx_reg     (rx_reg),
    .rx_valid   (rx_valid),
    .rx_count   (rx_count),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .rx_timeout (rx_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every rx_valid strobe, count error pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        words_seen++;
        valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_word: got %h expected none", rx_reg);
        end else begin
          check("word", rx_reg, exp_q.pop_front());
        end
      end
      if (frame_err === 1'b1) ferr_seen++;
      if (rx_timeout === 1'b1) to_seen++;
    end
  end

  // Called at a negedge; returns at the negedge ending the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic clr_at_stop);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (N) @(negedge clk);
    end
    rx = stop_bit;
    if (clr_at_stop) begin
      repeat (H + 3) @(negedge clk);
      rx_clr = 1'b1;
      @(negedge clk);
      rx_clr = 1'b0;
      repeat (N - H - 4) @(negedge clk);
    end else begin
      repeat (N) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [63:0] w);
    exp_q.push_back(w);
    for (int k = 7; k >= 0; k--) send_byte(w[8*k +: 8], 1'b1, 1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    rx     = 1'b1;
    rx_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rx_reg", rx_reg, 64'h0);
    check("reset_rx_valid", 64'(rx_valid), 64'h0);
    check("reset_rx_count", 64'(rx_count), 64'h0);
    check("reset_rx_busy", 64'(rx_busy), 64'h0);
    check("reset_frame_err", 64'(frame_err), 64'h0);
    check("reset_rx_timeout", 64'(rx_timeout), 64'h0);
    repeat (5) @(negedge clk);

    // Eight good bytes back-to-back, with strobe timing on the last byte.
    send_word(64'h0102030405060708);
    check("t1_rx_reg", rx_reg, 64'h0102030405060708);
    check("t1_rx_count", 64'(rx_count), 64'h0);
    check("t1_rx_busy", 64'(rx_busy), 64'h0);
    check("t1_valid_cycle", 64'(valid_cyc), 64'(start_cyc + 3 + H + 9 * N + 1));
    check("t1_words", 64'(words_seen), 64'd1);

    // Glitch: 20 low cycles never make it past the mid-bit recheck.
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_during", 64'(rx_busy), 64'h1);
    repeat (60) @(negedge clk);
    check("glitch_busy_after", 64'(rx_busy), 64'h0);
    check("glitch_rx_count", 64'(rx_count), 64'h0);
    check("glitch_no_ferr", 64'(ferr_seen), 64'd0);
    check("glitch_no_word", 64'(words_seen), 64'd1);

    // Framing error drops the partial word, then a clean word follows.
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'hBB, 1'b1, 1'b0);
    check("ferr_count_before", 64'(rx_count), 64'd2);
    send_byte(8'hCC, 1'b0, 1'b0);
    check("ferr_pulses", 64'(ferr_seen), 64'd1);
    check("ferr_rx_count", 64'(rx_count), 64'd0);
    send_word(64'hDEADBEEFCAFEF00D);
    check("ferr_rx_reg", rx_reg, 64'hDEADBEEFCAFEF00D);

    // Timeout: fires 1740 cycles after the last stop sample, not before.
    send_byte(8'h21, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h23, 1'b1, 1'b0);
    check("to_count_before", 64'(rx_count), 64'd3);
    repeat (1690) @(negedge clk);
    check("to_not_early", 64'(to_seen), 64'd0);
    check("to_count_holding", 64'(rx_count), 64'd3);
    repeat (20) @(negedge clk);
    check("to_pulses", 64'(to_seen), 64'd1);
    check("to_rx_count", 64'(rx_count), 64'd0);
    check("to_busy", 64'(rx_busy), 64'h0);
    send_word(64'h1122334455667788);
    check("to_rx_reg", rx_reg, 64'h1122334455667788);

    // Flush: rx_clr between bytes, then on the stop-sample edge of a byte.
    for (int k = 0; k < 5; k++) send_byte(8'h40 + 8'(k), 1'b1, 1'b0);
    check("flush_count_before", 64'(rx_count), 64'd5);
    rx_clr = 1'b1;
    @(negedge clk);
    rx_clr = 1'b0;
    check("flush_rx_count", 64'(rx_count), 64'd0);
    @(negedge clk);
    send_byte(8'h99, 1'b1, 1'b1);
    check("flush_stop_discard", 64'(rx_count), 64'd0);
    send_word(64'hA1B2C3D4E5F60718);
    check("flush_rx_reg", rx_reg, 64'hA1B2C3D4E5F60718);

    // Reset during DATA of byte 4, then a clean word.
    send_byte(8'h31, 1'b1, 1'b0);
    send_byte(8'h32, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    check("rst_count_before", 64'(rx_count), 64'd3);
    rx = 1'b0;
    repeat (N) @(negedge clk);
    rx = 1'b1;
    repeat (N) @(negedge clk);
    rx = 1'b0;
    repeat (N) @(negedge clk);
    rx = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_rx_reg", rx_reg, 64'h0);
    check("rst_rx_count", 64'(rx_count), 64'h0);
    check("rst_rx_busy", 64'(rx_busy), 64'h0);
    check("rst_rx_valid", 64'(rx_valid), 64'h0);
    check("rst_frame_err", 64'(frame_err), 64'h0);
    check("rst_rx_timeout", 64'(rx_timeout), 64'h0);
    repeat (5) @(negedge clk);
    send_word(64'h5A6996A500FF817E);
    check("rst_rx_reg_after", rx_reg, 64'h5A6996A500FF817E);

    repeat (10) @(negedge clk);
    check("final_words", 64'(words_seen), 64'd5);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_ferr_total", 64'(ferr_seen), 64'd1);
    check("final_to_total", 64'(to_seen), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
